wb_intercon_n: RTL and testbench

Parametrised single-master Wishbone classic interconnect that generalises the fixed four-slave decoder between the J1 CPU and its peripherals (ROM, RAM, board I/O, USB device controller) to N slaves with per-slave base/mask windows. It registers the address decode and watches every access with a timeout counter. Unmapped or stalled accesses end with a bus error instead of hanging the CPU. It sits in the `clk` domain between `cpu` and the slave blocks.

---
 rtl/wb_intercon_n_pkg.sv | 22 ++
 rtl/wb_addr_decode.sv | 28 ++
 rtl/wb_intercon_n.sv | 165 ++++++++++++++++
 tb/tb_wb_intercon_n.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_intercon_n_pkg.sv
// Shared types for the single-master Wishbone interconnect.
package wb_intercon_n_pkg;

  typedef enum logic [1:0] {
    WB_ERR_NONE    = 2'd0,
    WB_ERR_MISS    = 2'd1,
    WB_ERR_TIMEOUT = 2'd2,
    WB_ERR_SLAVE   = 2'd3
  } wb_err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } wb_ic_state_t;

  // Index width that stays at least one bit wide for a single-slave build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/mask window decoder; the lowest matching slave index wins.
module wb_addr_decode
  import wb_intercon_n_pkg::*;
#(
  parameter int NSLAVE = 4,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = idx_width(NSLAVE)
) (
  input  logic [ADDR_W-1:0]        adr,
  input  logic [NSLAVE*ADDR_W-1:0] base,
  input  logic [NSLAVE*ADDR_W-1:0] mask,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx
);

  // Scan from the highest index down so the lowest matching window is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((adr & mask[i*ADDR_W +: ADDR_W]) == base[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_intercon_n.sv
// Single-master Wishbone classic interconnect to N slaves with a registered
// decode, a per-access timeout and bus errors for unmapped or stalled accesses.
module wb_intercon_n
  import wb_intercon_n_pkg::*;
#(
  parameter int NSLAVE = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [NSLAVE*ADDR_W-1:0] SLAVE_BASE = {16'h9000, 16'h8000, 16'h4000, 16'h0000},
  parameter logic [NSLAVE*ADDR_W-1:0] SLAVE_MASK = {16'hFF00, 16'hFF00, 16'hC000, 16'hC000},
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     m_cyc,
  input  logic                     m_stb,
  input  logic                     m_we,
  input  logic [ADDR_W-1:0]        m_adr,
  input  logic [DATA_W-1:0]        m_dat_i,
  input  logic [DATA_W/8-1:0]      m_sel,
  output logic [DATA_W-1:0]        m_dat_o,
  output logic                     m_ack,
  output logic                     m_err,
  output logic [NSLAVE-1:0]        s_cyc,
  output logic [NSLAVE-1:0]        s_stb,
  output logic                     s_we,
  output logic [ADDR_W-1:0]        s_adr,
  output logic [DATA_W-1:0]        s_dat_o,
  output logic [DATA_W/8-1:0]      s_sel,
  input  logic [NSLAVE*DATA_W-1:0] s_dat_i,
  input  logic [NSLAVE-1:0]        s_ack,
  input  logic [NSLAVE-1:0]        s_err,
  output logic [1:0]               err_cause,
  output logic [ADDR_W-1:0]        err_adr
);

  localparam int IDX_W = idx_width(NSLAVE);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_ic_state_t      state;
  wb_err_t           err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic [NSLAVE-1:0] hot;
  logic              sel_ack;
  logic              sel_err;
  logic [DATA_W-1:0] sel_dat;

  wb_addr_decode #(
    .NSLAVE (NSLAVE),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_decode (
    .adr  (m_adr),
    .base (SLAVE_BASE),
    .mask (SLAVE_MASK),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // One-hot strobe pattern for the decoded slave, and the response of the latched slave only.
  always_comb begin
    hot     = '0;
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      hot[i] = (dec_idx == IDX_W'(i));
      if (idx_q == IDX_W'(i)) begin
        sel_ack = s_ack[i];
        sel_err = s_err[i];
        sel_dat = s_dat_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign err_cause = err_q;

  // Access sequencer: accept/decode, wait for the slave or the timeout, then pulse the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      cnt     <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_dat_o <= '0;
      s_cyc   <= '0;
      s_stb   <= '0;
      s_we    <= 1'b0;
      s_adr   <= '0;
      s_dat_o <= '0;
      s_sel   <= '0;
      err_q   <= WB_ERR_NONE;
      err_adr <= '0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m_cyc && m_stb) begin
            if (dec_hit) begin
              state   <= ST_BUSY;
              idx_q   <= dec_idx;
              cnt     <= '0;
              s_we    <= m_we;
              s_adr   <= m_adr;
              s_dat_o <= m_dat_i;
              s_sel   <= m_sel;
              s_cyc   <= hot;
              s_stb   <= hot;
            end else begin
              state   <= ST_RESP;
              m_err   <= 1'b1;
              err_q   <= WB_ERR_MISS;
              err_adr <= m_adr;
            end
          end
        end
        ST_BUSY: begin
          if (!m_cyc) begin
            state <= ST_IDLE;
            s_cyc <= '0;
            s_stb <= '0;
          end else if (sel_err) begin
            state   <= ST_RESP;
            m_err   <= 1'b1;
            err_q   <= WB_ERR_SLAVE;
            err_adr <= s_adr;
            s_cyc   <= '0;
            s_stb   <= '0;
          end else if (sel_ack) begin
            state <= ST_RESP;
            m_ack <= 1'b1;
            s_cyc <= '0;
            s_stb <= '0;
            if (!s_we) begin
              m_dat_o <= sel_dat;
            end
          end else if (cnt == CNT_LAST) begin
            state   <= ST_RESP;
            m_err   <= 1'b1;
            err_q   <= WB_ERR_TIMEOUT;
            err_adr <= s_adr;
            s_cyc   <= '0;
            s_stb   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_intercon_n.sv
// Self-checking bench for wb_intercon_n: directed and randomized accesses
// against a window/latency reference model, plus an overlapping-window instance.
module tb_wb_intercon_n;

  localparam int TO = 8;
  localparam logic [15:0] WIN_BASE [4] = '{16'h0000, 16'h4000, 16'h8000, 16'h9000};
  localparam logic [15:0] WIN_MASK [4] = '{16'hC000, 16'hC000, 16'hFF00, 16'hFF00};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_cyc, m_stb, m_we;
  logic [15:0] m_adr, m_dat_i;
  logic [1:0]  m_sel;
  logic [15:0] m_dat_o;
  logic        m_ack, m_err;
  logic [3:0]  s_cyc, s_stb;
  logic        s_we;
  logic [15:0] s_adr, s_dat_o;
  logic [1:0]  s_sel;
  logic [63:0] s_dat_i;
  logic [3:0]  s_ack, s_err;
  logic [1:0]  err_cause;
  logic [15:0] err_adr;

  logic [15:0] o_m_dat_o;
  logic        o_m_ack, o_m_err;
  logic [1:0]  o_s_cyc, o_s_stb;
  logic        o_s_we;
  logic [15:0] o_s_adr, o_s_dat_o;
  logic [1:0]  o_s_sel;
  logic [31:0] o_s_dat_i;
  logic [1:0]  o_s_ack, o_s_err;
  logic [1:0]  o_err_cause;
  logic [15:0] o_err_adr;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_dat = '0;
  logic [1:0]  exp_cause = '0;
  logic [15:0] exp_eadr = '0;
  logic [15:0] exp_ov_dat = '0;
  logic [1:0]  exp_ov_cause = '0;

  wb_intercon_n #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_i(m_dat_i), .m_sel(m_sel),
    .m_dat_o(m_dat_o), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err),
    .err_cause(err_cause), .err_adr(err_adr)
  );

  wb_intercon_n #(
    .NSLAVE(2), .SLAVE_BASE(32'h0000_0000), .SLAVE_MASK(32'h0000_0000), .TIMEOUT(TO)
  ) dut_ov (
    .clk(clk), .reset_n(reset_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_i(m_dat_i), .m_sel(m_sel),
    .m_dat_o(o_m_dat_o), .m_ack(o_m_ack), .m_err(o_m_err),
    .s_cyc(o_s_cyc), .s_stb(o_s_stb), .s_we(o_s_we), .s_adr(o_s_adr), .s_dat_o(o_s_dat_o),
    .s_sel(o_s_sel), .s_dat_i(o_s_dat_i), .s_ack(o_s_ack), .s_err(o_s_err),
    .err_cause(o_err_cause), .err_adr(o_err_adr)
  );

  // Reference decode: first window in index order whose masked address equals its base.
  function automatic int ref_target(input logic [15:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & WIN_MASK[i]) == WIN_BASE[i]) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One master access on the main instance; the bench plays the target slave.
  // waits < 0 means the slave never responds. Called and returns at a falling edge.
  task automatic applyStimulus(input logic [15:0] adr, input logic we, input logic [15:0] wdat,
                               input logic [1:0] sel, input int waits, input bit slv_err,
                               input logic [15:0] rdat);
    int tgt, cyc, k, exp_cyc;
    bit done, exp_is_err;
    logic [3:0] exp_hot, obs_stb;
    logic [1:0] cause_now, obs_cause;
    logic obs_ack, obs_err;
    logic [15:0] obs_dat, obs_eadr;
    tgt = ref_target(adr);
    exp_hot = (tgt >= 0) ? 4'(1 << tgt) : 4'b0000;
    if (tgt < 0) begin
      exp_cyc = 1; exp_is_err = 1'b1; cause_now = 2'd1;
    end else if (waits < 0) begin
      exp_cyc = TO + 1; exp_is_err = 1'b1; cause_now = 2'd2;
    end else begin
      exp_cyc = 2 + waits; exp_is_err = slv_err; cause_now = 2'd3;
    end
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_i = wdat; m_sel = sel;
    cyc = 0; k = 0; done = 1'b0;
    obs_ack = 1'b0; obs_err = 1'b0; obs_dat = '0; obs_eadr = '0; obs_cause = '0; obs_stb = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m_ack || m_err) begin
        done = 1'b1;
        obs_ack = m_ack; obs_err = m_err; obs_dat = m_dat_o;
        obs_cause = err_cause; obs_eadr = err_adr; obs_stb = s_stb;
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; s_err = '0;
      end else begin
        checkOutput("s_stb_busy", s_stb, exp_hot);
        if (cyc == 1 && tgt >= 0) begin
          checkOutput("s_cyc", s_cyc, exp_hot);
          checkOutput("s_req", {s_we, s_sel, s_adr, s_dat_o}, {we, sel, adr, wdat});
        end
        s_ack = 4'($urandom);
        s_err = 4'($urandom);
        s_dat_i = {$urandom, $urandom};
        if (tgt >= 0) begin
          s_ack[tgt] = 1'b0;
          s_err[tgt] = 1'b0;
          if (s_stb[tgt]) begin
            if (waits >= 0 && k == waits) begin
              if (slv_err) begin
                s_err[tgt] = 1'b1;
                s_ack[tgt] = 1'($urandom);
              end else begin
                s_ack[tgt] = 1'b1;
              end
              s_dat_i[tgt*16 +: 16] = rdat;
            end
            k++;
          end
        end
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; s_err = '0;
    if (exp_is_err) begin
      exp_cause = cause_now;
      exp_eadr = adr;
    end else if (!we) begin
      exp_dat = rdat;
    end
    checkOutput("resp_cycle", 64'(cyc), 64'(exp_cyc));
    checkOutput("m_ack", obs_ack, !exp_is_err);
    checkOutput("m_err", obs_err, exp_is_err);
    checkOutput("m_dat_o", obs_dat, exp_dat);
    checkOutput("err_cause", obs_cause, exp_cause);
    checkOutput("err_adr", obs_eadr, exp_eadr);
    checkOutput("s_stb_resp", obs_stb, 4'b0000);
    @(negedge clk);
    checkOutput("one_pulse", {m_ack, m_err}, 2'b00);
  endtask

  // One access on the overlapping-window instance; slave 0 must always be chosen.
  task automatic ovAccess(input logic [15:0] adr, input bit with_err);
    logic [15:0] d;
    d = 16'($urandom);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = adr; m_dat_i = 16'($urandom); m_sel = 2'b11;
    @(negedge clk);
    checkOutput("ov_s_stb", o_s_stb, 2'b01);
    o_s_ack = 2'b11;
    o_s_err = with_err ? 2'b11 : 2'b10;
    o_s_dat_i = {~d, d};
    @(negedge clk);
    if (with_err) begin
      exp_ov_cause = 2'd3;
    end else begin
      exp_ov_dat = d;
    end
    checkOutput("ov_resp", {o_m_ack, o_m_err}, with_err ? 2'b01 : 2'b10);
    checkOutput("ov_dat", o_m_dat_o, exp_ov_dat);
    checkOutput("ov_cause", o_err_cause, exp_ov_cause);
    m_cyc = 1'b0; m_stb = 1'b0; o_s_ack = '0; o_s_err = '0;
    @(negedge clk);
    checkOutput("ov_pulse", {o_m_ack, o_m_err}, 2'b00);
  endtask

  initial begin
    int w;
    logic [15:0] a;
    logic [1:0] held_cause;
    $display("[TB] wb_intercon_n bench starting");
    m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat_i = '0; m_sel = '0;
    s_dat_i = '0; s_ack = '0; s_err = '0;
    o_s_dat_i = '0; o_s_ack = '0; o_s_err = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ctl", {m_ack, m_err, s_cyc, s_stb, s_we, s_sel, err_cause}, '0);
    checkOutput("rst_data", {m_dat_o, s_adr, s_dat_o, err_adr}, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases: RAM read, USB write with wait states, unmapped, timeout.
    applyStimulus(16'h4002, 1'b0, 16'h0000, 2'b11, 0, 1'b0, 16'hBEEF);
    applyStimulus(16'h9004, 1'b1, 16'h1234, 2'b11, 3, 1'b0, 16'h5555);
    applyStimulus(16'hF000, 1'b0, 16'h0000, 2'b11, 0, 1'b0, 16'h0000);
    applyStimulus(16'h8000, 1'b0, 16'h0000, 2'b11, -1, 1'b0, 16'h0000);
    applyStimulus(16'h8010, 1'b0, 16'h0000, 2'b01, 1, 1'b1, 16'hAAAA);

    // Randomized accesses across all windows and the unmapped region.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: a = {2'b00, 14'($urandom)};
        1: a = {2'b01, 14'($urandom)};
        2: a = {8'h80, 8'($urandom)};
        3: a = {8'h90, 8'($urandom)};
        default: a = 16'($urandom);
      endcase
      w = $urandom_range(0, 5);
      if (w == 5) w = -1;
      applyStimulus(a, 1'($urandom), 16'($urandom), 2'($urandom), w,
                    ($urandom_range(0, 4) == 0), 16'($urandom));
    end

    // Abort: master drops cyc during a stalled access.
    held_cause = exp_cause;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 16'h4010; m_sel = 2'b11;
    @(negedge clk);
    checkOutput("abort_stb_on", s_stb, 4'b0010);
    @(negedge clk);
    m_cyc = 1'b0;
    @(negedge clk);
    checkOutput("abort_stb_off", {s_cyc, s_stb}, 8'h00);
    m_stb = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", {m_ack, m_err}, 2'b00);
    end
    checkOutput("abort_cause", err_cause, held_cause);

    // Reset asserted in the middle of a stalled access.
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 16'h0123;
    repeat (2) @(negedge clk);
    checkOutput("prereset_stb", s_stb, 4'b0001);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_ctl", {m_ack, m_err, s_cyc, s_stb, s_we, s_sel, err_cause}, '0);
    checkOutput("midrst_data", {m_dat_o, s_adr, s_dat_o, err_adr}, '0);
    m_cyc = 1'b0; m_stb = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Overlapping windows: slave 0 always wins; err beats ack on the same slave.
    for (int n = 0; n < 4; n++) begin
      ovAccess(16'($urandom), 1'b0);
    end
    ovAccess(16'h4567, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
